// File: rtl/cakegame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cakegame_pkg
// Description : Shared encodings for the cake memory game control unit:
//               FSM state numbers, display mux selects, sequence length and
//               the bundle of datapath control strobes.
// Revision    : 1.0 - initial release
// ============================================================================
package cakegame_pkg;

    // Game FSM states; the numeric value is exported on db_estado.
    typedef enum logic [3:0] {
        ST_INICIAL     = 4'd0,
        ST_PREPARA     = 4'd1,
        ST_CARREGA     = 4'd2,
        ST_FIM_CARGA   = 4'd3,
        ST_MOSTRA      = 4'd4,
        ST_PROX_MOSTRA = 4'd5,
        ST_FIM_MOSTRA  = 4'd6,
        ST_ESPERA      = 4'd7,
        ST_REGISTRA    = 4'd8,
        ST_COMPARA     = 4'd9,
        ST_PROX_JOGADA = 4'd10,
        ST_FIM_RODADA  = 4'd11,
        ST_NOVA_RODADA = 4'd12,
        ST_GANHOU      = 4'd13,
        ST_PERDEU      = 4'd14,
        ST_UNUSED      = 4'd15
    } state_t;

    // Display multiplexer selects.
    localparam logic [1:0] OUT_BLANK   = 2'd0;
    localparam logic [1:0] OUT_RAM     = 2'd1;
    localparam logic [1:0] OUT_BUTTONS = 2'd2;

    // Number of cakes in one round's sequence.
    localparam int SEQ_LEN = 16;

    // Every strobe the control unit drives into the datapath.
    typedef struct packed {
        logic [1:0] out_sel;
        logic       clear_reg;
        logic       enable_reg;
        logic       clear_mem_counter;
        logic       enable_mem_counter;
        logic       clear_show_counter;
        logic       enable_show_counter;
        logic       enable_timeout_counter;
        logic       clear_points_counter;
        logic       enable_points_counter;
        logic       clear_ram;
        logic       enable_ram;
        logic       reset_random;
        logic       pronto;
        logic       ganhou;
        logic       perdeu;
    } ctrl_t;

    // All strobes inactive, display blank.
    localparam ctrl_t CTRL_IDLE = '0;

    // True in the end-of-game states, where iniciar restarts the game.
    function automatic logic is_game_over(input state_t st);
        return (st == ST_GANHOU) || (st == ST_PERDEU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cakegame_uc.sv
`default_nettype none
// ============================================================================
// Module      : cakegame_uc
// Description : Moore control unit of the cake memory game. Loads a random
//               16-cake sequence, shows it, then checks the player's plays
//               one by one; tracks rounds through the datapath points
//               counter and reports win/loss.
// Revision    : 1.0 - initial release
// ============================================================================
module cakegame_uc
    import cakegame_pkg::*;
#(
    parameter int WIN_POINTS = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       end_mem_counter,
    input  logic       correct_play,
    input  logic       has_play,
    input  logic       end_show,
    input  logic       half_show,
    input  logic       timeout,
    input  logic [2:0] points,
    output logic [1:0] out_sel,
    output logic       clear_reg,
    output logic       enable_reg,
    output logic       clear_mem_counter,
    output logic       enable_mem_counter,
    output logic       clear_show_counter,
    output logic       enable_show_counter,
    output logic       enable_timeout_counter,
    output logic       clear_points_counter,
    output logic       enable_points_counter,
    output logic       clear_ram,
    output logic       enable_ram,
    output logic       reset_random,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic [3:0] db_estado
);

    // Points value seen in FIM_RODADA (before its increment) on the final round.
    localparam logic [2:0] c_last_round = 3'(WIN_POINTS - 1);

    state_t state_q;
    state_t state_d;
    ctrl_t  w_ctrl;

    // Next-state: game flow from the current state and datapath status flags.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INICIAL: begin
                if (iniciar) begin
                    state_d = ST_PREPARA;
                end
            end
            ST_PREPARA: begin
                state_d = ST_CARREGA;
            end
            ST_CARREGA: begin
                // Address 15 is written in the same cycle we leave.
                if (end_mem_counter) begin
                    state_d = ST_FIM_CARGA;
                end
            end
            ST_FIM_CARGA: begin
                state_d = ST_MOSTRA;
            end
            ST_MOSTRA: begin
                if (end_show) begin
                    state_d = ST_PROX_MOSTRA;
                end
            end
            ST_PROX_MOSTRA: begin
                state_d = end_mem_counter ? ST_FIM_MOSTRA : ST_MOSTRA;
            end
            ST_FIM_MOSTRA: begin
                state_d = ST_ESPERA;
            end
            ST_ESPERA: begin
                // A press in the same cycle as the timeout still counts.
                if (has_play) begin
                    state_d = ST_REGISTRA;
                end else if (timeout) begin
                    state_d = ST_PERDEU;
                end
            end
            ST_REGISTRA: begin
                state_d = ST_COMPARA;
            end
            ST_COMPARA: begin
                if (!correct_play) begin
                    state_d = ST_PERDEU;
                end else if (end_mem_counter) begin
                    state_d = ST_FIM_RODADA;
                end else begin
                    state_d = ST_PROX_JOGADA;
                end
            end
            ST_PROX_JOGADA: begin
                state_d = ST_ESPERA;
            end
            ST_FIM_RODADA: begin
                state_d = (points == c_last_round) ? ST_GANHOU : ST_NOVA_RODADA;
            end
            ST_NOVA_RODADA: begin
                state_d = ST_CARREGA;
            end
            ST_GANHOU, ST_PERDEU: begin
                if (iniciar) begin
                    state_d = ST_PREPARA;
                end
            end
            default: begin
                state_d = ST_INICIAL;
            end
        endcase
    end

    // State register; reset drops straight back to INICIAL.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INICIAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode: strobes depend on state only, except the MOSTRA blank gap
    // and the PROX_MOSTRA address step which is suppressed at the last entry.
    always_comb begin
        w_ctrl = CTRL_IDLE;
        case (state_q)
            ST_PREPARA: begin
                w_ctrl.clear_reg            = 1'b1;
                w_ctrl.clear_mem_counter    = 1'b1;
                w_ctrl.clear_show_counter   = 1'b1;
                w_ctrl.clear_points_counter = 1'b1;
                w_ctrl.clear_ram            = 1'b1;
                w_ctrl.reset_random         = 1'b1;
            end
            ST_CARREGA: begin
                w_ctrl.enable_ram         = 1'b1;
                w_ctrl.enable_mem_counter = 1'b1;
            end
            ST_FIM_CARGA: begin
                w_ctrl.clear_mem_counter  = 1'b1;
                w_ctrl.clear_show_counter = 1'b1;
            end
            ST_MOSTRA: begin
                w_ctrl.enable_show_counter = 1'b1;
                w_ctrl.out_sel             = half_show ? OUT_BLANK : OUT_RAM;
            end
            ST_PROX_MOSTRA: begin
                w_ctrl.clear_show_counter = 1'b1;
                w_ctrl.enable_mem_counter = !end_mem_counter;
            end
            ST_FIM_MOSTRA: begin
                w_ctrl.clear_mem_counter = 1'b1;
                w_ctrl.clear_reg         = 1'b1;
            end
            ST_ESPERA: begin
                // Timer clear is the inverse of this enable, so it restarts per entry.
                w_ctrl.enable_timeout_counter = 1'b1;
                w_ctrl.out_sel                = OUT_BUTTONS;
            end
            ST_REGISTRA: begin
                w_ctrl.enable_reg = 1'b1;
                w_ctrl.out_sel    = OUT_BUTTONS;
            end
            ST_COMPARA: begin
                w_ctrl.out_sel = OUT_BUTTONS;
            end
            ST_PROX_JOGADA: begin
                w_ctrl.enable_mem_counter = 1'b1;
                w_ctrl.clear_reg          = 1'b1;
            end
            ST_FIM_RODADA: begin
                w_ctrl.enable_points_counter = 1'b1;
            end
            ST_NOVA_RODADA: begin
                // No reseed here: the generators keep running into a new sequence.
                w_ctrl.clear_mem_counter  = 1'b1;
                w_ctrl.clear_ram          = 1'b1;
                w_ctrl.clear_show_counter = 1'b1;
                w_ctrl.clear_reg          = 1'b1;
            end
            ST_GANHOU: begin
                w_ctrl.pronto  = is_game_over(state_q);
                w_ctrl.ganhou  = 1'b1;
                w_ctrl.out_sel = OUT_BLANK;
            end
            ST_PERDEU: begin
                // Show the cake the player should have pressed.
                w_ctrl.pronto  = is_game_over(state_q);
                w_ctrl.perdeu  = 1'b1;
                w_ctrl.out_sel = OUT_RAM;
            end
            default: begin
                w_ctrl = CTRL_IDLE;
            end
        endcase
    end

    assign out_sel                = w_ctrl.out_sel;
    assign clear_reg              = w_ctrl.clear_reg;
    assign enable_reg             = w_ctrl.enable_reg;
    assign clear_mem_counter      = w_ctrl.clear_mem_counter;
    assign enable_mem_counter     = w_ctrl.enable_mem_counter;
    assign clear_show_counter     = w_ctrl.clear_show_counter;
    assign enable_show_counter    = w_ctrl.enable_show_counter;
    assign enable_timeout_counter = w_ctrl.enable_timeout_counter;
    assign clear_points_counter   = w_ctrl.clear_points_counter;
    assign enable_points_counter  = w_ctrl.enable_points_counter;
    assign clear_ram              = w_ctrl.clear_ram;
    assign enable_ram             = w_ctrl.enable_ram;
    assign reset_random           = w_ctrl.reset_random;
    assign pronto                 = w_ctrl.pronto;
    assign ganhou                 = w_ctrl.ganhou;
    assign perdeu                 = w_ctrl.perdeu;
    assign db_estado              = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cakegame_uc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cakegame_uc
// Description : Bench for cakegame_uc. A small datapath emulation (address and
//               points counters) feeds the status flags back; a game-flow
//               reference predicts every cycle's outputs into a queue that a
//               separate monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cakegame_uc;

    localparam int WIN_POINTS = 7;

    // Game phases, numbered as exported on db_estado.
    localparam int S_INICIAL = 0,  S_PREPARA = 1,  S_CARREGA = 2,  S_FIM_CARGA = 3;
    localparam int S_MOSTRA = 4,   S_PROX_MOSTRA = 5, S_FIM_MOSTRA = 6, S_ESPERA = 7;
    localparam int S_REGISTRA = 8, S_COMPARA = 9, S_PROX_JOGADA = 10, S_FIM_RODADA = 11;
    localparam int S_NOVA_RODADA = 12, S_GANHOU = 13, S_PERDEU = 14;

    // Strobe bit positions inside the expected control word.
    localparam logic [14:0] M_CLR_REG = 15'h4000, M_EN_REG  = 15'h2000;
    localparam logic [14:0] M_CLR_MEM = 15'h1000, M_EN_MEM  = 15'h0800;
    localparam logic [14:0] M_CLR_SHW = 15'h0400, M_EN_SHW  = 15'h0200;
    localparam logic [14:0] M_EN_TO   = 15'h0100, M_CLR_PTS = 15'h0080;
    localparam logic [14:0] M_EN_PTS  = 15'h0040, M_CLR_RAM = 15'h0020;
    localparam logic [14:0] M_EN_RAM  = 15'h0010, M_RST_RND = 15'h0008;
    localparam logic [14:0] M_PRONTO  = 15'h0004, M_GANHOU  = 15'h0002;
    localparam logic [14:0] M_PERDEU  = 15'h0001;

    // Stimulus flavours.
    localparam int M_WIN = 0, M_ROUND_THEN_TO = 1, M_WRONG5 = 2, M_SIM = 3, M_RAND = 4;

    typedef struct packed {
        logic [3:0]  st;
        logic [1:0]  sel;
        logic [14:0] ctl;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       end_mem_counter = 1'b0;
    logic       correct_play = 1'b0;
    logic       has_play = 1'b0;
    logic       end_show = 1'b0;
    logic       half_show = 1'b0;
    logic       timeout = 1'b0;
    logic [2:0] points = 3'd0;

    logic [1:0] out_sel;
    logic       clear_reg, enable_reg, clear_mem_counter, enable_mem_counter;
    logic       clear_show_counter, enable_show_counter, enable_timeout_counter;
    logic       clear_points_counter, enable_points_counter, clear_ram, enable_ram;
    logic       reset_random, pronto, ganhou, perdeu;
    logic [3:0] db_estado;

    cakegame_uc #(.WIN_POINTS(WIN_POINTS)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .iniciar                (iniciar),
        .end_mem_counter        (end_mem_counter),
        .correct_play           (correct_play),
        .has_play               (has_play),
        .end_show               (end_show),
        .half_show              (half_show),
        .timeout                (timeout),
        .points                 (points),
        .out_sel                (out_sel),
        .clear_reg              (clear_reg),
        .enable_reg             (enable_reg),
        .clear_mem_counter      (clear_mem_counter),
        .enable_mem_counter     (enable_mem_counter),
        .clear_show_counter     (clear_show_counter),
        .enable_show_counter    (enable_show_counter),
        .enable_timeout_counter (enable_timeout_counter),
        .clear_points_counter   (clear_points_counter),
        .enable_points_counter  (enable_points_counter),
        .clear_ram              (clear_ram),
        .enable_ram             (enable_ram),
        .reset_random           (reset_random),
        .pronto                 (pronto),
        .ganhou                 (ganhou),
        .perdeu                 (perdeu),
        .db_estado              (db_estado)
    );

    always #5 clock = ~clock;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          budget_hits = 0;
    int          budget_seen = 0;
    int          cyc = 0;

    // Reference state of the game flow plus emulated datapath counters.
    int          mstate = S_INICIAL;
    int          addr_emul = 0;
    int          pts_emul = 0;
    int          pts_off = 0;
    logic [14:0] ctl_tbl [0:15];

    // Strobes each phase asserts, read off the game description.
    function automatic exp_t model_out(input int s, input logic emc, input logic half);
        exp_t e;
        e.st  = 4'(s);
        e.ctl = ctl_tbl[s];
        if (s == S_PROX_MOSTRA && !emc) e.ctl = e.ctl | M_EN_MEM;
        if (s == S_MOSTRA)                                       e.sel = half ? 2'd0 : 2'd1;
        else if (s == S_ESPERA || s == S_REGISTRA || s == S_COMPARA) e.sel = 2'd2;
        else if (s == S_PERDEU)                                  e.sel = 2'd1;
        else                                                     e.sel = 2'd0;
        return e;
    endfunction

    // Where the game goes next, given this cycle's status flags.
    function automatic int model_next(input int s, input logic ini, input logic emc,
                                      input logic cp, input logic hp, input logic es,
                                      input logic to, input logic [2:0] pts);
        if (s == S_INICIAL || s == S_GANHOU || s == S_PERDEU) return ini ? S_PREPARA : s;
        if (s == S_PREPARA || s == S_NOVA_RODADA)            return S_CARREGA;
        if (s == S_CARREGA)                                  return emc ? S_FIM_CARGA : S_CARREGA;
        if (s == S_FIM_CARGA)                                return S_MOSTRA;
        if (s == S_MOSTRA)                                   return es ? S_PROX_MOSTRA : S_MOSTRA;
        if (s == S_PROX_MOSTRA)                              return emc ? S_FIM_MOSTRA : S_MOSTRA;
        if (s == S_FIM_MOSTRA || s == S_PROX_JOGADA)         return S_ESPERA;
        if (s == S_ESPERA)                                   return hp ? S_REGISTRA : (to ? S_PERDEU : S_ESPERA);
        if (s == S_REGISTRA)                                 return S_COMPARA;
        if (s == S_COMPARA) begin
            if (!cp)  return S_PERDEU;
            if (emc)  return S_FIM_RODADA;
            return S_PROX_JOGADA;
        end
        if (s == S_FIM_RODADA) return (int'(pts) == WIN_POINTS - 1) ? S_GANHOU : S_NOVA_RODADA;
        return S_INICIAL;
    endfunction

    // One clock of stimulus: drive, predict, then advance model and datapath.
    task automatic step(input logic rst_v, input logic ini_v, input int mode);
        logic c_mem, e_mem, c_pts, e_pts;
        reset        = rst_v;
        iniciar      = ini_v;
        half_show    = 1'($urandom_range(1, 0));
        end_show     = ($urandom_range(2, 0) == 0);
        end_mem_counter = (addr_emul == 15);
        points       = 3'(pts_emul + pts_off);
        has_play     = 1'($urandom_range(1, 0));
        timeout      = 1'($urandom_range(1, 0));
        correct_play = 1'($urandom_range(1, 0));
        if (mstate == S_ESPERA) begin
            has_play = ($urandom_range(2, 0) == 0);
            case (mode)
                M_WIN, M_WRONG5:  timeout = 1'b0;
                M_ROUND_THEN_TO:  timeout = (pts_emul >= 1) && ($urandom_range(3, 0) == 0);
                M_SIM: begin
                    if (addr_emul < 3) timeout = has_play;
                    else begin has_play = 1'b0; timeout = 1'b1; end
                end
                default:          timeout = ($urandom_range(19, 0) == 0);
            endcase
        end
        if (mstate == S_COMPARA) begin
            case (mode)
                M_WRONG5: correct_play = (addr_emul != 4);
                M_RAND:   correct_play = ($urandom_range(15, 0) != 0);
                default:  correct_play = 1'b1;
            endcase
        end
        if (!rst_v) mstate = S_INICIAL;
        exp_q.push_back(model_out(mstate, end_mem_counter, half_show));
        @(negedge clock);
        c_mem = clear_mem_counter;     e_mem = enable_mem_counter;
        c_pts = clear_points_counter;  e_pts = enable_points_counter;
        @(posedge clock);
        if (c_mem)      addr_emul = 0;
        else if (e_mem) addr_emul = (addr_emul + 1) % 16;
        if (c_pts)      pts_emul = 0;
        else if (e_pts) pts_emul = (pts_emul + 1) % 8;
        if (rst_v)
            mstate = model_next(mstate, iniciar, end_mem_counter, correct_play,
                                has_play, end_show, timeout, points);
        #1;
    endtask

    // Start a game and play it to the end (or the cycle budget), then idle.
    task automatic run_game(input int mode, input int off);
        int n;
        pts_off = off;
        step(1'b1, 1'b1, mode);
        n = 0;
        while (mstate != S_GANHOU && mstate != S_PERDEU && n < 4000) begin
            step(1'b1, ($urandom_range(7, 0) == 0), mode);
            n++;
        end
        if (n >= 4000) budget_hits++;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, mode);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest prediction.
    always @(negedge clock) begin
        exp_t e;
        exp_t act;
        cyc++;
        if (budget_seen != budget_hits) begin
            budget_seen = budget_hits;
            total++;
            bad++;
            $display("FAIL game_budget: game still running after cycle budget, state=%0d", db_estado);
        end
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {db_estado, out_sel, clear_reg, enable_reg, clear_mem_counter,
                   enable_mem_counter, clear_show_counter, enable_show_counter,
                   enable_timeout_counter, clear_points_counter, enable_points_counter,
                   clear_ram, enable_ram, reset_random, pronto, ganhou, perdeu};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL cycle_outputs @%0d: got state=%0d sel=%0d ctl=%b, expected state=%0d sel=%0d ctl=%b",
                         cyc, act.st, act.sel, act.ctl, e.st, e.sel, e.ctl);
            end
        end
    end

    initial begin
        int guard;
        for (int i = 0; i < 16; i++) ctl_tbl[i] = '0;
        ctl_tbl[S_PREPARA]     = M_CLR_REG | M_CLR_MEM | M_CLR_SHW | M_CLR_PTS | M_CLR_RAM | M_RST_RND;
        ctl_tbl[S_CARREGA]     = M_EN_RAM | M_EN_MEM;
        ctl_tbl[S_FIM_CARGA]   = M_CLR_MEM | M_CLR_SHW;
        ctl_tbl[S_MOSTRA]      = M_EN_SHW;
        ctl_tbl[S_PROX_MOSTRA] = M_CLR_SHW;
        ctl_tbl[S_FIM_MOSTRA]  = M_CLR_MEM | M_CLR_REG;
        ctl_tbl[S_ESPERA]      = M_EN_TO;
        ctl_tbl[S_REGISTRA]    = M_EN_REG;
        ctl_tbl[S_PROX_JOGADA] = M_EN_MEM | M_CLR_REG;
        ctl_tbl[S_FIM_RODADA]  = M_EN_PTS;
        ctl_tbl[S_NOVA_RODADA] = M_CLR_MEM | M_CLR_RAM | M_CLR_SHW | M_CLR_REG;
        ctl_tbl[S_GANHOU]      = M_PRONTO | M_GANHOU;
        ctl_tbl[S_PERDEU]      = M_PRONTO | M_PERDEU;

        @(posedge clock);
        #1;
        // Power-up in reset, then release with no start request.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, M_WIN);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, M_WIN);

        // Start a game and yank reset while waiting for the first play.
        pts_off = 0;
        step(1'b1, 1'b1, M_WIN);
        guard = 0;
        while (mstate != S_ESPERA && guard < 2000) begin
            step(1'b1, 1'b0, M_WIN);
            guard++;
        end
        if (guard >= 2000) budget_hits++;
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, M_WIN);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, M_WIN);

        run_game(M_ROUND_THEN_TO, 0);   // one full round, then lose by timeout
        run_game(M_WIN, 6);             // last round won -> GANHOU
        run_game(M_SIM, 0);             // press+timeout together, then timeout alone
        run_game(M_WRONG5, 0);          // wrong fifth play
        for (int g = 0; g < 6; g++) run_game(M_RAND, int'($urandom_range(6, 0)));

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        @(negedge clock);
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
